// File: rtl/frontend_response_tracker.sv
// Return path of the frontend request interface: holds the tags of accepted requests and pairs
// in-order backend completions with them, presenting tagged responses on a valid/ready channel.
module frontend_response_tracker #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic                       issue_op,
  input  logic [4:0]                 issue_id,
  input  logic [1:0]                 issue_core,
  output logic                       issue_ready,
  input  logic                       rdata_valid,
  input  logic [DATA_W-1:0]          rdata,
  input  logic                       wr_done,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_op,
  output logic [4:0]                 resp_id,
  output logic [1:0]                 resp_core,
  output logic [DATA_W-1:0]          resp_data,
  output logic [$clog2(DEPTH)+1:0]   outstanding_cnt,
  output logic                       err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + AW'(1);
  endfunction

  function automatic logic [CW-1:0] cnt_step(input logic [CW-1:0] c, input logic inc,
                                             input logic dec);
    return c + CW'(inc) - CW'(dec);
  endfunction

  // Tag storage: read and write tags kept separately so each completion stream pairs in order.
  logic [4:0]        rd_id_mem   [DEPTH];
  logic [1:0]        rd_core_mem [DEPTH];
  logic [4:0]        wr_id_mem   [DEPTH];
  logic [1:0]        wr_core_mem [DEPTH];
  logic [DATA_W-1:0] d_mem       [DEPTH];

  logic [AW-1:0] rd_wptr, rd_rptr, wr_wptr, wr_rptr, d_wptr, d_rptr;
  logic [CW-1:0] rd_cnt, wr_cnt, d_cnt, wd_cnt;
  logic [CW-1:0] rd_cnt_nxt, wr_cnt_nxt, d_cnt_nxt, wd_cnt_nxt;

  logic rd_push, wr_push, d_acc, w_acc;
  logic rd_pend, wr_pend, can_load, load_rd, load_wr;
  logic arb_rd;
  logic [DATA_W-1:0] rd_head_data;

  assign issue_ready = issue_op ? (rd_cnt != FULL_CNT) : (wr_cnt != FULL_CNT);
  assign rd_push     = issue_valid && issue_op && (rd_cnt != FULL_CNT);
  assign wr_push     = issue_valid && !issue_op && (wr_cnt != FULL_CNT);

  // A completion is only accepted when an unmatched tag is already stored, so the tag head
  // always exists when the completion is served, even on the same-cycle bypass path.
  assign d_acc = rdata_valid && (d_cnt < rd_cnt);
  assign w_acc = wr_done && (wd_cnt < wr_cnt);

  assign rd_pend  = (d_cnt != '0) || d_acc;
  assign wr_pend  = (wd_cnt != '0) || w_acc;
  assign can_load = !resp_valid || resp_ready;
  assign load_rd  = can_load && rd_pend && (!wr_pend || arb_rd);
  assign load_wr  = can_load && wr_pend && !load_rd;

  assign rd_head_data = (d_cnt != '0) ? d_mem[d_rptr] : rdata;

  assign rd_cnt_nxt = cnt_step(rd_cnt, rd_push, load_rd);
  assign wr_cnt_nxt = cnt_step(wr_cnt, wr_push, load_wr);
  assign d_cnt_nxt  = cnt_step(d_cnt, d_acc, load_rd);
  assign wd_cnt_nxt = cnt_step(wd_cnt, w_acc, load_wr);

  always_ff @(posedge clk) begin
    if (rd_push) begin
      rd_id_mem[rd_wptr]   <= issue_id;
      rd_core_mem[rd_wptr] <= issue_core;
    end
    if (wr_push) begin
      wr_id_mem[wr_wptr]   <= issue_id;
      wr_core_mem[wr_wptr] <= issue_core;
    end
    if (d_acc) d_mem[d_wptr] <= rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_wptr         <= '0;
      rd_rptr         <= '0;
      wr_wptr         <= '0;
      wr_rptr         <= '0;
      d_wptr          <= '0;
      d_rptr          <= '0;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      d_cnt           <= '0;
      wd_cnt          <= '0;
      outstanding_cnt <= '0;
      err_orphan      <= 1'b0;
      arb_rd          <= 1'b1;
    end else begin
      if (rd_push) rd_wptr <= ptr_inc(rd_wptr);
      if (wr_push) wr_wptr <= ptr_inc(wr_wptr);
      if (d_acc)   d_wptr  <= ptr_inc(d_wptr);
      if (load_rd) begin
        rd_rptr <= ptr_inc(rd_rptr);
        d_rptr  <= ptr_inc(d_rptr);
      end
      if (load_wr) wr_rptr <= ptr_inc(wr_rptr);
      rd_cnt          <= rd_cnt_nxt;
      wr_cnt          <= wr_cnt_nxt;
      d_cnt           <= d_cnt_nxt;
      wd_cnt          <= wd_cnt_nxt;
      outstanding_cnt <= {1'b0, rd_cnt_nxt} + {1'b0, wr_cnt_nxt};
      if ((rdata_valid && !d_acc) || (wr_done && !w_acc)) err_orphan <= 1'b1;
      // Next tie goes to the type not just served.
      if (load_rd)      arb_rd <= 1'b0;
      else if (load_wr) arb_rd <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_op    <= 1'b0;
      resp_id    <= '0;
      resp_core  <= '0;
      resp_data  <= '0;
    end else if (load_rd) begin
      resp_valid <= 1'b1;
      resp_op    <= 1'b1;
      resp_id    <= rd_id_mem[rd_rptr];
      resp_core  <= rd_core_mem[rd_rptr];
      resp_data  <= rd_head_data;
    end else if (load_wr) begin
      resp_valid <= 1'b1;
      resp_op    <= 1'b0;
      resp_id    <= wr_id_mem[wr_rptr];
      resp_core  <= wr_core_mem[wr_rptr];
      resp_data  <= '0;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frontend_response_tracker.sv
// Directed bench for frontend_response_tracker with hand-computed expected responses.
module tb_frontend_response_tracker;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid, issue_op, issue_ready;
  logic [4:0]        issue_id;
  logic [1:0]        issue_core;
  logic              rdata_valid, wr_done;
  logic [DATA_W-1:0] rdata;
  logic              resp_valid, resp_ready, resp_op;
  logic [4:0]        resp_id;
  logic [1:0]        resp_core;
  logic [DATA_W-1:0] resp_data;
  logic [4:0]        outstanding_cnt;
  logic              err_orphan;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  frontend_response_tracker #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_id(issue_id),
    .issue_core(issue_core), .issue_ready(issue_ready),
    .rdata_valid(rdata_valid), .rdata(rdata), .wr_done(wr_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
    .resp_id(resp_id), .resp_core(resp_core), .resp_data(resp_data),
    .outstanding_cnt(outstanding_cnt), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [4:0] id, input logic [1:0] core);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_id    = id;
    issue_core  = core;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic op, input logic [4:0] id,
                            input logic [1:0] core, input logic [127:0] data);
    check({tag, "_valid"}, 128'(resp_valid), 128'(1));
    check({tag, "_op"},    128'(resp_op),    128'(op));
    check({tag, "_id"},    128'(resp_id),    128'(id));
    check({tag, "_core"},  128'(resp_core),  128'(core));
    check({tag, "_data"},  resp_data,        data);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 0; issue_op = 0; issue_id = '0; issue_core = '0;
    rdata_valid = 0; rdata = '0; wr_done = 0; resp_ready = 0;
    tick(); tick();
    check("rst_valid", 128'(resp_valid), 128'(0));
    check("rst_cnt",   128'(outstanding_cnt), 128'(0));
    check("rst_err",   128'(err_orphan), 128'(0));
    check("rst_id",    128'(resp_id), 128'(0));
    check("rst_data",  resp_data, 128'(0));
    rst = 1'b0;

    // Single read round trip
    issue_valid = 1; issue_op = 1; issue_id = 5'd3; issue_core = 2'd1;
    #1 check("t1_ready", 128'(issue_ready), 128'(1));
    tick(); issue_valid = 0;
    check("t1_cnt1", 128'(outstanding_cnt), 128'(1));
    tick();
    rdata_valid = 1; rdata = 128'hA5; resp_ready = 1;
    tick(); rdata_valid = 0;
    check_resp("t1", 1'b1, 5'd3, 2'd1, 128'hA5);
    check("t1_cnt0", 128'(outstanding_cnt), 128'(0));
    tick();
    check("t1_idle", 128'(resp_valid), 128'(0));

    // Fill the read tag FIFO, then drain at full throughput
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 5'(i), 2'd0);
    issue_valid = 1; issue_op = 1; issue_id = 5'd20;
    #1 check("t2_full_rd", 128'(issue_ready), 128'(0));
    tick(); issue_valid = 0;
    check("t2_cnt8", 128'(outstanding_cnt), 128'(8));
    issue_op = 0;
    #1 check("t2_wr_ready", 128'(issue_ready), 128'(1));
    issue_op = 1;
    rdata_valid = 1; rdata = 128'h100; resp_ready = 1;
    tick(); rdata_valid = 0;
    check_resp("t2_first", 1'b1, 5'd0, 2'd0, 128'h100);
    check("t2_cnt7", 128'(outstanding_cnt), 128'(7));
    check("t2_rd_ready", 128'(issue_ready), 128'(1));
    for (int i = 1; i < DEPTH; i++) begin
      rdata_valid = 1; rdata = 128'(256 + i);
      tick();
      check("t2_drain_valid", 128'(resp_valid), 128'(1));
      check("t2_drain_id", 128'(resp_id), 128'(i));
      check("t2_drain_data", resp_data, 128'(256 + i));
    end
    rdata_valid = 0;
    tick();
    check("t2_end_valid", 128'(resp_valid), 128'(0));
    check("t2_end_cnt", 128'(outstanding_cnt), 128'(0));

    // Backpressure: payload holds while ready is low
    issue(1'b1, 5'd7, 2'd2);
    resp_ready = 0; rdata_valid = 1; rdata = 128'h77;
    tick(); rdata_valid = 0;
    for (int k = 0; k < 4; k++) begin
      check("t3_hold_valid", 128'(resp_valid), 128'(1));
      check("t3_hold_id", 128'(resp_id), 128'(7));
      check("t3_hold_data", resp_data, 128'h77);
      tick();
    end
    check("t3_pre_valid", 128'(resp_valid), 128'(1));
    resp_ready = 1;
    tick();
    check("t3_consumed", 128'(resp_valid), 128'(0));
    check("t3_cnt", 128'(outstanding_cnt), 128'(0));

    // Simultaneous read and write completions, from a fresh arbitration state
    rst = 1; tick(); rst = 0;
    issue(1'b1, 5'd1, 2'd0);
    issue(1'b0, 5'd2, 2'd3);
    check("t4_cnt2", 128'(outstanding_cnt), 128'(2));
    rdata_valid = 1; rdata = 128'hBEEF; wr_done = 1; resp_ready = 1;
    tick(); rdata_valid = 0; wr_done = 0;
    check_resp("t4_rd", 1'b1, 5'd1, 2'd0, 128'hBEEF);
    tick();
    check_resp("t4_wr", 1'b0, 5'd2, 2'd3, 128'h0);
    tick();
    check("t4_idle", 128'(resp_valid), 128'(0));
    check("t4_cnt0", 128'(outstanding_cnt), 128'(0));

    // Orphan completions
    check("t5_err_pre", 128'(err_orphan), 128'(0));
    rdata_valid = 1; rdata = 128'hDEAD;
    tick(); rdata_valid = 0;
    check("t5_err_rd", 128'(err_orphan), 128'(1));
    check("t5_no_resp", 128'(resp_valid), 128'(0));
    check("t5_cnt", 128'(outstanding_cnt), 128'(0));
    tick(); tick();
    check("t5_sticky", 128'(err_orphan), 128'(1));
    wr_done = 1;
    tick(); wr_done = 0;
    check("t5_err_wr", 128'(err_orphan), 128'(1));
    tick();
    check("t5_no_resp2", 128'(resp_valid), 128'(0));
    check("t5_cnt2", 128'(outstanding_cnt), 128'(0));

    // Reset mid-operation
    issue(1'b1, 5'd4, 2'd0);
    issue(1'b1, 5'd5, 2'd0);
    issue(1'b1, 5'd6, 2'd0);
    resp_ready = 0; rdata_valid = 1; rdata = 128'h44;
    tick(); rdata_valid = 0;
    check("t6_pre_valid", 128'(resp_valid), 128'(1));
    check("t6_pre_cnt", 128'(outstanding_cnt), 128'(2));
    rst = 1; tick(); rst = 0;
    check("t6_cnt", 128'(outstanding_cnt), 128'(0));
    check("t6_valid", 128'(resp_valid), 128'(0));
    check("t6_err", 128'(err_orphan), 128'(0));
    check("t6_id", 128'(resp_id), 128'(0));
    issue(1'b1, 5'd9, 2'd1);
    rdata_valid = 1; rdata = 128'h99; resp_ready = 1;
    tick(); rdata_valid = 0;
    check_resp("t6_new", 1'b1, 5'd9, 2'd1, 128'h99);
    check("t6_new_cnt", 128'(outstanding_cnt), 128'(0));
    tick();
    check("t6_idle", 128'(resp_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
